// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave controller digit-entry path.
//   KEY_W      : number of keypad lines (digits 0-9)
//   BCD_W      : width of one BCD digit
//   MAX_DIGITS : digits the Timer holds (ones, tens, mins)
//   TENS_MAX   : largest digit the mod-6 tens stage can hold
//   kl_state_t : key-entry FSM states
//   is_onehot / key_to_bcd : keypad pattern helpers
package microwave_pkg;

  localparam int unsigned KEY_W = 10;
  localparam int unsigned BCD_W = 4;

  localparam logic [1:0]       MAX_DIGITS = 2'd3;
  localparam logic [BCD_W-1:0] TENS_MAX   = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_ACCEPT   = 2'd2,
    ST_RELEASE  = 2'd3
  } kl_state_t;

  function automatic logic is_onehot(input logic [KEY_W-1:0] k);
    return (k != '0) && ((k & (k - KEY_W'(1))) == '0);
  endfunction

  // Bit i maps to value i; only meaningful for a one-hot pattern.
  function automatic logic [BCD_W-1:0] key_to_bcd(input logic [KEY_W-1:0] k);
    logic [BCD_W-1:0] d;
    d = '0;
    for (int unsigned i = 0; i < KEY_W; i++) begin
      if (k[i]) d = BCD_W'(i);
    end
    return d;
  endfunction

endpackage

// File: rtl/keypad_loader_if.sv
// Serial BCD load bus between the keypad loader and the Timer.
//   data       : BCD digit presented to the Timer
//   loadn      : active-low one-cycle load strobe
//   timer_busy : Timer is counting, key entry disabled
//   entry_clr  : synchronous clear issued alongside the Timer clear
// master = keypad_loader side, slave = Timer side.
interface keypad_loader_if;
  import microwave_pkg::*;

  logic [BCD_W-1:0] data;
  logic             loadn;
  logic             timer_busy;
  logic             entry_clr;

  modport master (
    output data,
    output loadn,
    input  timer_busy,
    input  entry_clr
  );

  modport slave (
    input  data,
    input  loadn,
    output timer_busy,
    output entry_clr
  );

endinterface

// File: rtl/key_debouncer.sv
// Synchronises the raw keypad lines, waits for a stable pattern, emits a
// single accept pulse per press and then waits for a stable release.
//   clk    : system clock
//   clr    : asynchronous active-high reset
//   keys   : raw, bouncy keypad lines
//   accept : high for the one cycle the FSM sits in ST_ACCEPT
//   kcap   : pattern captured at the start of debounce (valid with accept)
module key_debouncer
  import microwave_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned DB_W            = 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [KEY_W-1:0] keys,
  output logic             accept,
  output logic [KEY_W-1:0] kcap
);

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [KEY_W-1:0] sync1, ksync;
  logic [KEY_W-1:0] kcap_next;
  logic [DB_W-1:0]  cnt, cnt_next;
  kl_state_t        state, state_next;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync1 <= '0;
      ksync <= '0;
      kcap  <= '0;
      cnt   <= '0;
      state <= ST_IDLE;
    end else begin
      sync1 <= keys;
      ksync <= sync1;
      kcap  <= kcap_next;
      cnt   <= cnt_next;
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    kcap_next  = kcap;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ksync != '0) begin
          kcap_next  = ksync;
          cnt_next   = '0;
          state_next = ST_DEBOUNCE;
        end
      end
      ST_DEBOUNCE: begin
        if (ksync != kcap) begin
          state_next = ST_IDLE;
        end else if (cnt == CNT_LAST) begin
          state_next = ST_ACCEPT;
        end else begin
          cnt_next = cnt + DB_W'(1);
        end
      end
      ST_ACCEPT: begin
        accept     = 1'b1;
        cnt_next   = '0;
        state_next = ST_RELEASE;
      end
      ST_RELEASE: begin
        // Any activity restarts the quiet period, so a held key never repeats.
        if (ksync != '0) begin
          cnt_next = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt + DB_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/keypad_loader.sv
// Keypad digit-entry front end for the microwave Timer. Debounces one-hot
// keypad presses, encodes them to BCD and shifts accepted digits into the
// Timer with a one-cycle active-low strobe, rejecting entries the Timer
// cannot hold.
//   clk       : system clock
//   clr       : asynchronous active-high reset
//   keys      : raw keypad lines, bit i = digit i
//   tmr       : Timer load bus (data, loadn out; timer_busy, entry_clr in)
//   digit_cnt : digits entered since clear, saturating at 3
//   key_err   : one-cycle pulse when a debounced press is rejected
module keypad_loader
  import microwave_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned DB_W            = 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [KEY_W-1:0] keys,
  keypad_loader_if.master  tmr,
  output logic [1:0]       digit_cnt,
  output logic             key_err
);

  logic             accept;
  logic [KEY_W-1:0] kcap;

  logic [BCD_W-1:0] s0, s1, s2;
  logic [BCD_W-1:0] data_q;
  logic [1:0]       cnt_q;

  logic             onehot, full, tens_bad, take, strobe;
  logic [BCD_W-1:0] d;

  key_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .DB_W            (DB_W)
  ) u_debouncer (
    .clk    (clk),
    .clr    (clr),
    .keys   (keys),
    .accept (accept),
    .kcap   (kcap)
  );

  // Decisions are combinational on the ACCEPT cycle so the strobe and the
  // digit appear in that same cycle; an async clr drops loadn at once.
  always_comb begin
    onehot   = is_onehot(kcap);
    d        = key_to_bcd(kcap);
    full     = (cnt_q == MAX_DIGITS);
    tens_bad = (cnt_q != 2'd0) && (s0 > TENS_MAX);
    key_err  = accept && (!onehot || (!tmr.timer_busy && (full || tens_bad)));
    take     = accept && onehot && !tmr.timer_busy && !full && !tens_bad;
    strobe   = take && !tmr.entry_clr;
    tmr.loadn = !strobe;
    tmr.data  = strobe ? d : data_q;
    digit_cnt = cnt_q;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      s0     <= '0;
      s1     <= '0;
      s2     <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else if (tmr.entry_clr) begin
      s0     <= '0;
      s1     <= '0;
      s2     <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else if (take) begin
      s2     <= s1;
      s1     <= s0;
      s0     <= d;
      data_q <= d;
      cnt_q  <= cnt_q + 2'd1;
    end
  end

endmodule

// File: tb/tb_keypad_loader.sv
module tb_keypad_loader;
  import microwave_pkg::*;

  localparam int unsigned N = 16;

  logic        clk = 1'b0;
  logic        clr;
  logic [9:0]  keys;
  logic [1:0]  digit_cnt;
  logic        key_err;

  keypad_loader_if kif();

  keypad_loader #(
    .DEBOUNCE_CYCLES (N),
    .DB_W            (5)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .keys      (keys),
    .tmr       (kif),
    .digit_cnt (digit_cnt),
    .key_err   (key_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strobes = 0;
  int errs = 0;
  int last_strobe_cyc = 0;
  int press_cyc = 0;
  logic prev_loadn = 1'b1;
  logic [3:0] exp_q[$];

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] km(input int unsigned dig);
    logic [9:0] one;
    one = 10'd1;
    return one << dig;
  endfunction

  always @(posedge clk) cyc++;

  // Scoreboard side: every strobe must match the oldest expected digit.
  always @(negedge clk) begin
    if (!clr) begin
      if (kif.loadn === 1'b0) begin
        strobes++;
        last_strobe_cyc = cyc;
        check("loadn_single_cycle", prev_loadn, 1);
        check("strobe_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("strobe_data", kif.data, exp_q.pop_front());
      end
      if (key_err === 1'b1) begin
        errs++;
        check("err_excl_strobe", kif.loadn, 1);
      end
      prev_loadn = kif.loadn;
    end else begin
      prev_loadn = 1'b1;
    end
  end

  task automatic press(input logic [9:0] k, input int hold);
    @(negedge clk);
    keys = k;
    press_cyc = cyc;
    repeat (hold) @(negedge clk);
    keys = '0;
    repeat (40) @(negedge clk);
  endtask

  task automatic pulse_entry_clr();
    @(negedge clk);
    kif.entry_clr = 1'b1;
    @(negedge clk);
    kif.entry_clr = 1'b0;
  endtask

  int s_base, e_base, lat;

  initial begin
    keys = '0;
    clr = 1'b1;
    kif.timer_busy = 1'b0;
    kif.entry_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", kif.data, 0);
    check("rst_loadn", kif.loadn, 1);
    check("rst_cnt", digit_cnt, 0);
    check("rst_err", key_err, 0);
    clr = 1'b0;
    repeat (2) @(negedge clk);

    // Single clean press of 5 held 40 cycles
    s_base = strobes; e_base = errs;
    exp_q.push_back(4'd5);
    press(km(5), 40);
    check("k5_strobes", strobes - s_base, 1);
    check("k5_errs", errs - e_base, 0);
    check("k5_cnt", digit_cnt, 1);
    check("k5_data_hold", kif.data, 5);
    lat = last_strobe_cyc - press_cyc;
    check("k5_latency", (lat >= int'(N) + 2) && (lat <= int'(N) + 4), 1);

    pulse_entry_clr();
    check("eclr_cnt", digit_cnt, 0);
    check("eclr_data", kif.data, 0);

    // Bouncing 3 then stable
    s_base = strobes;
    exp_q.push_back(4'd3);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      keys = (i % 2 == 0) ? km(3) : 10'd0;
      repeat (3) @(negedge clk);
    end
    check("bounce_no_early", strobes - s_base, 0);
    keys = km(3);
    press_cyc = cyc;
    repeat (40) @(negedge clk);
    keys = '0;
    repeat (40) @(negedge clk);
    check("bounce_strobes", strobes - s_base, 1);
    lat = last_strobe_cyc - press_cyc;
    check("bounce_latency", (lat >= int'(N) + 2) && (lat <= int'(N) + 4), 1);
    check("bounce_cnt", digit_cnt, 1);

    pulse_entry_clr();

    // 1, 3, 0 then a rejected fourth digit
    s_base = strobes; e_base = errs;
    exp_q.push_back(4'd1); press(km(1), 30);
    exp_q.push_back(4'd3); press(km(3), 30);
    exp_q.push_back(4'd0); press(km(0), 30);
    check("seq_strobes", strobes - s_base, 3);
    check("seq_cnt", digit_cnt, 3);
    check("seq_errs", errs - e_base, 0);
    s_base = strobes; e_base = errs;
    press(km(9), 30);
    check("full_err", errs - e_base, 1);
    check("full_strobes", strobes - s_base, 0);
    check("full_cnt", digit_cnt, 3);
    check("full_data", kif.data, 0);

    // Digit too large for the tens stage
    pulse_entry_clr();
    exp_q.push_back(4'd7); press(km(7), 30);
    check("k7_cnt", digit_cnt, 1);
    s_base = strobes; e_base = errs;
    press(km(2), 30);
    check("tens_err", errs - e_base, 1);
    check("tens_strobes", strobes - s_base, 0);
    check("tens_cnt", digit_cnt, 1);
    check("tens_data", kif.data, 7);

    // Busy timer and multi-key press
    pulse_entry_clr();
    s_base = strobes; e_base = errs;
    kif.timer_busy = 1'b1;
    press(km(4), 30);
    kif.timer_busy = 1'b0;
    check("busy_strobes", strobes - s_base, 0);
    check("busy_errs", errs - e_base, 0);
    check("busy_cnt", digit_cnt, 0);
    press(km(2) | km(6), 30);
    check("multi_err", errs - e_base, 1);
    check("multi_strobes", strobes - s_base, 0);

    // Async reset during debounce
    exp_q.push_back(4'd6); press(km(6), 30);
    check("pre_rst_cnt", digit_cnt, 1);
    s_base = strobes;
    @(negedge clk);
    keys = km(8);
    repeat (8) @(negedge clk);
    clr = 1'b1;
    #1;
    check("midrst_data", kif.data, 0);
    check("midrst_loadn", kif.loadn, 1);
    check("midrst_cnt", digit_cnt, 0);
    check("midrst_err", key_err, 0);
    keys = '0;
    @(negedge clk);
    clr = 1'b0;
    repeat (40) @(negedge clk);
    check("midrst_strobes", strobes - s_base, 0);
    exp_q.push_back(4'd8); press(km(8), 30);
    check("k8_strobes", strobes - s_base, 1);
    check("k8_cnt", digit_cnt, 1);
    check("k8_data", kif.data, 8);

    // entry_clr overlapping the accept cycle suppresses the strobe
    s_base = strobes; e_base = errs;
    @(negedge clk);
    keys = km(4);
    repeat (N + 1) @(negedge clk);
    kif.entry_clr = 1'b1;
    repeat (4) @(negedge clk);
    kif.entry_clr = 1'b0;
    repeat (20) @(negedge clk);
    keys = '0;
    repeat (40) @(negedge clk);
    check("eclr_acc_strobes", strobes - s_base, 0);
    check("eclr_acc_errs", errs - e_base, 0);
    check("eclr_acc_cnt", digit_cnt, 0);
    check("eclr_acc_data", kif.data, 0);

    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_loader.md
Name: keypad_loader

Overview:
- Front-end digit-entry block for the microwave controller. Drives the Timer's serial BCD load interface (`data` and `loadn`).
- Takes raw one-hot keypad lines (keys 0-9), then synchronises, debounces and encodes them to BCD.
- Each accepted key becomes a one-cycle active-low `loadn` strobe, so digits shift into ones → tens → mins.
- Tracks entered digits locally and rejects entries the mod-6 tens stage cannot hold. Ignores keys while the timer runs.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive cycles a synchronised key pattern must be stable before it is accepted (≥2).
- DB_W, 5, debounce counter width; must satisfy 2^DB_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock; all state on rising edge.
- clr  input  1  asynchronous, active-high reset.
- keys  input  10  raw keypad lines, bit i = digit i pressed. Asynchronous to clk and bouncy.
- timer_busy  input  1  high while the Timer is counting; key entry is disabled.
- entry_clr  input  1  synchronous; clears the local digit shadow and count. Asserted together with the Timer's clear.
- data  output  4  BCD digit presented to the Timer.
- loadn  output  1  active-low load strobe to the Timer, exactly one cycle per accepted digit.
- digit_cnt  output  2  digits entered since clear, saturating at 3.
- key_err  output  1  one-cycle pulse when a debounced press is rejected.

Behaviour:
- Reset (clr high, asynchronous):
  - data=0, loadn=1, digit_cnt=0, key_err=0.
  - Shadow digits s0, s1, s2 = 0; FSM returns to IDLE; debounce counter = 0.
  - Reset mid-strobe deasserts loadn immediately.
- Synchroniser: keys pass through a 2-flop synchroniser, giving ksync. All decisions use ksync.
- FSM states: IDLE, DEBOUNCE, ACCEPT, RELEASE.
- IDLE:
  - If ksync ≠ 0, capture ksync into kcap, clear the counter, go to DEBOUNCE.
- DEBOUNCE:
  - If ksync ≠ kcap, return to IDLE.
  - Otherwise increment the counter.
  - When counter == DEBOUNCE_CYCLES-1 with ksync still equal to kcap, go to ACCEPT.
- ACCEPT (single cycle) evaluates conditions in this priority order:
  1. kcap not one-hot (two or more keys): key_err=1.
  2. timer_busy=1: ignore silently, no error.
  3. digit_cnt==3: key_err=1; saturated, no shift.
  4. digit_cnt≥1 and s0>5 (that digit would move into the mod-6 tens stage): key_err=1.
  5. Otherwise, accept:
     - Encode kcap to BCD d (bit i → value i).
     - Drive data=d and loadn=0 during this cycle.
     - Shift s2←s1, s1←s0, s0←d; increment digit_cnt.
  - Always go to RELEASE next.
- RELEASE:
  - Wait until ksync == 0 for DEBOUNCE_CYCLES consecutive cycles, then go to IDLE.
  - Any nonzero ksync restarts the release count.
  - No auto-repeat: holding a key never produces a second strobe.
- Latency: a clean press stable from cycle t produces loadn=0 at cycle t+2+DEBOUNCE_CYCLES+1, ±1 cycle for synchroniser phase.
- Output holding:
  - data holds its last loaded value after the strobe; it changes only in an accepting ACCEPT cycle or on reset/entry_clr.
  - loadn is never low for two consecutive cycles.
- entry_clr:
  - Clears s0..s2, digit_cnt and data to 0; FSM state is unaffected.
  - If asserted in the same cycle as an accepting ACCEPT, entry_clr wins: no strobe, loadn stays 1.
- timer_busy rising mid-debounce: the press is evaluated at ACCEPT using the current timer_busy.
- key_err and loadn=0 are mutually exclusive.

Decomposition:
- Shared package `microwave_pkg`:
  - FSM state encoding constants.
  - MAX_DIGITS = 3.
  - TENS_MAX = 5.
  - BCD width = 4.
- One natural sub-module: `key_debouncer`. It contains the synchroniser, the stable-pattern counter and an `accept` pulse. It is instantiated once.
- Encoding and shadow logic live in keypad_loader.

Test Plan:
- Reset, then key 5 held for 40 cycles with DEBOUNCE_CYCLES=16 → exactly one loadn=0 cycle with data=4'd5, digit_cnt=1, key_err never high.
- Key 3 bouncing (toggling every 3 cycles for 30 cycles), then stable → exactly one strobe with data=3, issued only after 16 stable cycles.
- Press sequence 1, 3, 0 → three strobes with data 1, 3, 0; digit_cnt=3. A fourth key 9 → key_err pulse, no strobe, digit_cnt stays 3.
- entry_clr, press 7 → strobe with data=7. Press 2 → key_err pulse (s0=7 >5), no strobe, digit_cnt=1.
- timer_busy=1, press 4 → no strobe, no key_err. Keys 2 and 6 pressed together → key_err pulse, no strobe.
- Assert clr for 1 cycle during DEBOUNCE of key 8 → all outputs at reset values, no strobe. After release, press 8 → normal strobe with data=8.
